spi_reg_access_ctrl: RTL and testbench

// - Serial-side sequencer for the configuration/readback register bank.
// - Deserialises a command byte from PICO and drives the 59:1 readback mux select.
// - Streams the selected register out on POCI, LSB first, and issues write strobes into the bank.
// - Supports burst access with address auto-increment while cs_n stays low.

---
 rtl/spi_reg_access_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_reg_access_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_access_ctrl.sv
// spi_reg_access_ctrl: serial-side sequencer for the config/readback register bank.
// A command byte picks the start address and direction; data streams LSB first with auto-increment.
module spi_reg_access_ctrl #(
    parameter int NUM_REGS = 59,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       cs_n,
    input  logic       pico,
    input  logic [7:0] mux_data,
    output logic [7:0] mux_sel,
    output logic       poci,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       addr_err
);

    localparam logic [6:0] LAST = 7'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] cmd_sr;
    logic [6:0] wd_sr;
    logic [6:0] shadow;
    logic [6:0] addr;
    logic       addr_vld;
    logic       cmd_vld;
    logic [6:0] nxt_addr;

    // Address range check on the assembled command, and the wrap-to-1 increment
    always_comb begin
        cmd_vld  = (cmd_sr != 7'd0) && (cmd_sr <= LAST);
        nxt_addr = (addr >= LAST) ? 7'd1 : addr + 7'd1;
    end

    // Transaction sequencer: command deserialise, read streaming, write strobes
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            cmd_sr   <= 7'd0;
            wd_sr    <= 7'd0;
            shadow   <= 7'd0;
            addr     <= 7'd0;
            addr_vld <= 1'b0;
            mux_sel  <= 8'd0;
            poci     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 8'd0;
            wr_data  <= 8'd0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (cs_n) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                poci    <= 1'b0;
                mux_sel <= 8'd0;
                busy    <= 1'b0;
            end else begin
                busy    <= 1'b1;
                bit_cnt <= bit_cnt + 3'd1;
                unique case (state)
                    IDLE: begin
                        cmd_sr   <= {pico, cmd_sr[6:1]};
                        addr_err <= 1'b0;
                        poci     <= 1'b0;
                        state    <= CMD;
                    end
                    CMD: begin
                        poci <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            // cmd_sr holds address bits 0..6; pico is the write flag
                            addr     <= cmd_sr;
                            addr_vld <= cmd_vld;
                            mux_sel  <= cmd_vld ? {1'b0, cmd_sr} : 8'd0;
                            if (!cmd_vld) begin
                                addr_err <= 1'b1;
                            end
                            state <= pico ? WRITE : READ;
                        end else begin
                            cmd_sr <= {pico, cmd_sr[6:1]};
                        end
                    end
                    READ: begin
                        if (bit_cnt == 3'd0) begin
                            shadow <= addr_vld ? mux_data[7:1] : 7'd0;
                            poci   <= addr_vld & mux_data[0];
                        end else begin
                            shadow <= {1'b0, shadow[6:1]};
                            poci   <= shadow[0];
                        end
                        if (bit_cnt == 3'd7) begin
                            if (!addr_vld) begin
                                addr_err <= 1'b1;
                            end else if (AUTO_INC) begin
                                addr    <= nxt_addr;
                                mux_sel <= {1'b0, nxt_addr};
                            end
                        end
                    end
                    WRITE: begin
                        wd_sr <= {pico, wd_sr[6:1]};
                        if (bit_cnt == 3'd7) begin
                            if (addr_vld) begin
                                wr_en   <= 1'b1;
                                wr_addr <= {1'b0, addr};
                                wr_data <= {pico, wd_sr};
                                if (AUTO_INC) begin
                                    addr    <= nxt_addr;
                                    mux_sel <= {1'b0, nxt_addr};
                                end
                            end else begin
                                addr_err <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// tb_spi_reg_access_ctrl: directed vectors for the SPI register sequencer.
// Readback mux modelled as a fixed table: reg[i] = i ^ 8'h5A, reg5 = 8'hA6, reg0 = 0.
module tb_spi_reg_access_ctrl;

    logic       sclk;
    logic       rstn;
    logic       cs_n;
    logic       pico;
    logic [7:0] mux_data;
    logic [7:0] mux_sel;
    logic       poci;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       addr_err;

    logic [7:0] regs [0:255];

    int n_chk;
    int n_fail;
    int wr_pulses;

    typedef struct {
        logic [7:0]  cmd;
        int          nb;
        logic [23:0] din;
        logic [23:0] exp;
        logic [23:0] ea;
        logic        err;
    } vec_t;

    vec_t tv [10];

    spi_reg_access_ctrl #(
        .NUM_REGS(59),
        .AUTO_INC(1'b1)
    ) dut (
        .sclk    (sclk),
        .rstn    (rstn),
        .cs_n    (cs_n),
        .pico    (pico),
        .mux_data(mux_data),
        .mux_sel (mux_sel),
        .poci    (poci),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .addr_err(addr_err)
    );

    assign mux_data = regs[mux_sel];

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One sclk edge: drive at negedge, sample 1 time unit after posedge
    task automatic drive(input logic c, input logic p);
        @(negedge sclk);
        cs_n = c;
        pico = p;
        @(posedge sclk);
        #1;
        if (wr_en) wr_pulses++;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [7:0] got;
        int         wr0;
        int         wexp;
        wr0  = wr_pulses;
        wexp = 0;
        got  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, v.cmd[i]);
            if (i == 0) chk({tag, ":busy_cmd"}, 32'(busy), 32'd1);
            if (i == 7) chk({tag, ":poci_cmd"}, 32'(poci), 32'd0);
        end
        chk({tag, ":msel_cmd"}, 32'(mux_sel), 32'(v.ea[7:0]));
        chk({tag, ":err_cmd"}, 32'(addr_err), 32'(v.err));
        for (int b = 0; b < v.nb; b++) begin
            for (int k = 0; k < 8; k++) begin
                drive(1'b0, v.din[b*8+k]);
                got[k] = poci;
                if (k == 0) begin
                    chk({tag, ":msel_byte"}, 32'(mux_sel), 32'(v.ea[b*8 +: 8]));
                end
                if (k == 7 && v.cmd[7] && v.ea[b*8 +: 8] != 8'd0) begin
                    wexp++;
                    chk({tag, ":wr_en"}, 32'(wr_en), 32'd1);
                    chk({tag, ":wr_addr"}, 32'(wr_addr), 32'(v.ea[b*8 +: 8]));
                    chk({tag, ":wr_data"}, 32'(wr_data), 32'(v.din[b*8 +: 8]));
                end
            end
            if (!v.cmd[7]) begin
                chk({tag, ":rd_byte"}, 32'(got), 32'(v.exp[b*8 +: 8]));
            end
        end
        drive(1'b1, 1'b0);
        chk({tag, ":busy_end"}, 32'(busy), 32'd0);
        chk({tag, ":msel_end"}, 32'(mux_sel), 32'd0);
        chk({tag, ":poci_end"}, 32'(poci), 32'd0);
        chk({tag, ":err_end"}, 32'(addr_err), 32'(v.err));
        chk({tag, ":wr_cnt"}, 32'(wr_pulses - wr0), 32'(wexp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":msel"}, 32'(mux_sel), 32'd0);
        chk({tag, ":poci"}, 32'(poci), 32'd0);
        chk({tag, ":wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, ":wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, ":wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, ":busy"}, 32'(busy), 32'd0);
        chk({tag, ":err"}, 32'(addr_err), 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        wr_pulses = 0;
        for (int i = 0; i < 256; i++) begin
            regs[i] = (i >= 1 && i <= 59) ? (8'(i) ^ 8'h5A) : 8'h00;
        end
        regs[5] = 8'hA6;

        //          cmd    nb  din         exp         ea          err
        tv[0] = '{8'h05, 1, 24'h000000, 24'h0000A6, 24'h000005, 1'b0};
        tv[1] = '{8'h3A, 3, 24'h000000, 24'h5B6160, 24'h013B3A, 1'b0};
        tv[2] = '{8'h8A, 1, 24'h00003C, 24'h000000, 24'h00000A, 1'b0};
        tv[3] = '{8'h8A, 2, 24'h00813C, 24'h000000, 24'h000B0A, 1'b0};
        tv[4] = '{8'h00, 1, 24'h000000, 24'h000000, 24'h000000, 1'b1};
        tv[5] = '{8'h3C, 2, 24'h000000, 24'h000000, 24'h000000, 1'b1};
        tv[6] = '{8'hBC, 1, 24'h000055, 24'h000000, 24'h000000, 1'b1};
        tv[7] = '{8'h01, 1, 24'h000000, 24'h00005B, 24'h000001, 1'b0};
        tv[8] = '{8'h3B, 2, 24'h000000, 24'h005B61, 24'h00013B, 1'b0};
        tv[9] = '{8'hBB, 2, 24'h00F00F, 24'h000000, 24'h00013B, 1'b0};

        rstn = 1'b0;
        cs_n = 1'b1;
        pico = 1'b0;
        #2;
        chk_all_zero("reset");
        @(negedge sclk);
        rstn = 1'b1;
        drive(1'b1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            run_txn(tv[t], $sformatf("vec%0d", t));
        end

        // Abort on the 5th edge of a write data byte
        begin
            int w0;
            logic [7:0] c;
            c  = 8'h8A;
            w0 = wr_pulses;
            for (int i = 0; i < 8; i++) drive(1'b0, c[i]);
            for (int k = 0; k < 4; k++) drive(1'b0, 1'b1);
            drive(1'b1, 1'b1);
            chk("abort:busy", 32'(busy), 32'd0);
            chk("abort:msel", 32'(mux_sel), 32'd0);
            chk("abort:wr_en", 32'(wr_en), 32'd0);
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b0);
            chk("abort:wr_cnt", 32'(wr_pulses - w0), 32'd0);
            run_txn(tv[0], "abort_next");
        end

        // Async reset in the middle of a read byte
        begin
            logic [7:0] c;
            c = 8'h3A;
            for (int i = 0; i < 8; i++) drive(1'b0, c[i]);
            for (int k = 0; k < 3; k++) drive(1'b0, 1'b0);
            chk("arst:busy_pre", 32'(busy), 32'd1);
            rstn = 1'b0;
            #1;
            chk_all_zero("arst");
            @(negedge sclk);
            cs_n = 1'b1;
            @(negedge sclk);
            rstn = 1'b1;
            drive(1'b1, 1'b0);
            run_txn(tv[0], "arst_next");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
